// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multi-cycle MIPS controller and the blocks that
// consume its outputs (ALUCtrl, RegMUX, CPU top). Keeping the opcode, state
// and select encodings in one place means every block reads the same values.
//   - opcode constants for the supported instructions
//   - FSM state encodings (4 bits, 13..15 unused)
//   - ALUOp, alu_src_b and pc_source encodings
//   - ctrl_word_t: the full control word produced per state
//   - dispatch_state(): DECODE-stage opcode -> next state
// ---------------------------------------------------------------------------
package mips_pkg;

    // Opcodes, taken from instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // FSM state encodings; the numeric values are visible on the debug port
    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_MADDR  = 4'd2;
    localparam logic [3:0] ST_MRD    = 4'd3;
    localparam logic [3:0] ST_MWB    = 4'd4;
    localparam logic [3:0] ST_MWR    = 4'd5;
    localparam logic [3:0] ST_REXE   = 4'd6;
    localparam logic [3:0] ST_RWB    = 4'd7;
    localparam logic [3:0] ST_BRN    = 4'd8;
    localparam logic [3:0] ST_JMP    = 4'd9;
    localparam logic [3:0] ST_AEXE   = 4'd10;
    localparam logic [3:0] ST_AWB    = 4'd11;
    localparam logic [3:0] ST_TRAP   = 4'd12;

    // ALUOp as seen by ALUCtrl
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Complete set of datapath controls driven by the FSM in one state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_word_t;

    // Every control inactive; used as the default for each state
    localparam ctrl_word_t CTRL_IDLE = '0;

    // Next state out of DECODE. Optional instructions that are disabled fall
    // through to TRAP exactly like any unknown opcode.
    function automatic logic [3:0] dispatch_state(input logic [5:0] op,
                                                  input logic       en_addi,
                                                  input logic       en_jump);
        logic [3:0] nxt;
        nxt = ST_TRAP;
        case (op)
            OP_RTYPE:     nxt = ST_REXE;
            OP_LW, OP_SW: nxt = ST_MADDR;
            OP_BEQ:       nxt = ST_BRN;
            OP_J:         nxt = en_jump ? ST_JMP : ST_TRAP;
            OP_ADDI:      nxt = en_addi ? ST_AEXE : ST_TRAP;
            default:      nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl_decode
// Combinational lookup from the registered FSM state to the control word.
// Outputs are Moore-style except the few places where a state finishes only
// when memory answers (FETCH loads IR/PC, MWR reports completion).
// Ports:
//   state      in   4  current FSM state
//   mem_ready  in   1  memory handshake; only looked at in FETCH and MWR
//   ctrl       out     control word (ctrl_word_t) for the datapath
// ---------------------------------------------------------------------------
module mips_mc_ctrl_decode
    import mips_pkg::*;
(
    input  logic [3:0]  state,
    input  logic        mem_ready,
    output ctrl_word_t  ctrl
);

    // Start from all-inactive so any unlisted control, unused state or TRAP
    // drives zero; each state then switches on only what it needs.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                // PC+4 is computed every fetch cycle, but the PC and IR only
                // load once the instruction word is actually on the bus.
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MWR: begin
                // The store is finished only in the cycle memory accepts it
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_REXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRN: begin
                // Compare by subtraction; PC takes the target held in ALUOut
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            ST_JMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            ST_AEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_AWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// mips_mc_ctrl
// Multi-cycle main control FSM for the MIPS datapath. Sequences
// fetch/decode/execute/memory/writeback, waits on the memory handshake and
// traps permanently (until reset) on an illegal opcode.
// Parameters:
//   EN_ADDI  1: decode addi, 0: addi is illegal
//   EN_JUMP  1: decode j,    0: j is illegal
// Ports:
//   clk, rst               clock, async active-high reset
//   opcode[5:0]            instr[31:26], evaluated in DECODE
//   mem_ready              memory finished the current access
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, RegDst, RegWrite, alu_src_a, alu_src_b[1:0], ALUOp[1:0],
//   pc_source[1:0]         datapath controls
//   state[3:0]             current FSM state (debug)
//   illegal_op             sticky trap flag
//   instr_done             pulse in the last cycle of each instruction
// ---------------------------------------------------------------------------
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       instr_done
);

    logic [3:0] state_next;
    logic       mem_is_store;
    ctrl_word_t ctrl;

    // The opcode is only trusted in DECODE, so the load/store direction is
    // captured there and reused in MADDR instead of re-reading the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_is_store <= 1'b0;
        end else if (state == ST_DECODE) begin
            mem_is_store <= (opcode == OP_SW);
        end
    end

    // Next-state logic; unused encodings recover to FETCH and TRAP only
    // leaves through reset.
    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH:  state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_next = dispatch_state(opcode, EN_ADDI, EN_JUMP);
            ST_MADDR:  state_next = mem_is_store ? ST_MWR : ST_MRD;
            ST_MRD:    state_next = mem_ready ? ST_MWB : ST_MRD;
            ST_MWB:    state_next = ST_FETCH;
            ST_MWR:    state_next = mem_ready ? ST_FETCH : ST_MWR;
            ST_REXE:   state_next = ST_RWB;
            ST_RWB:    state_next = ST_FETCH;
            ST_BRN:    state_next = ST_FETCH;
            ST_JMP:    state_next = ST_FETCH;
            ST_AEXE:   state_next = ST_AWB;
            ST_AWB:    state_next = ST_FETCH;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_FETCH;
        endcase
    end

    // State register; reset lands in FETCH immediately, abandoning whatever
    // instruction was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // The flag rises on the same edge that enters TRAP and holds until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (state_next == ST_TRAP) begin
            illegal_op <= 1'b1;
        end
    end

    mips_mc_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign RegDst        = ctrl.reg_dst;
    assign RegWrite      = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign ALUOp         = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign instr_done    = ctrl.instr_done;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_ctrl
// Self-checking bench for the multi-cycle MIPS controller. A full-featured
// instance runs a per-cycle vector table covering every instruction class;
// a second instance with addi/j disabled checks the illegal-opcode paths.
// ---------------------------------------------------------------------------
module tb_mips_mc_ctrl;

    // Bit positions of the flattened control word, in the order of cw_a
    localparam logic [16:0] B_PCW  = 17'h10000;
    localparam logic [16:0] B_PCWC = 17'h08000;
    localparam logic [16:0] B_IORD = 17'h04000;
    localparam logic [16:0] B_MRD  = 17'h02000;
    localparam logic [16:0] B_MWR  = 17'h01000;
    localparam logic [16:0] B_IRW  = 17'h00800;
    localparam logic [16:0] B_M2R  = 17'h00400;
    localparam logic [16:0] B_RDST = 17'h00200;
    localparam logic [16:0] B_RWR  = 17'h00100;
    localparam logic [16:0] B_SRCA = 17'h00080;
    localparam logic [16:0] SRCB1  = 17'h00020;
    localparam logic [16:0] SRCB2  = 17'h00040;
    localparam logic [16:0] SRCB3  = 17'h00060;
    localparam logic [16:0] ALUOP1 = 17'h00008;
    localparam logic [16:0] ALUOP2 = 17'h00010;
    localparam logic [16:0] PCSRC1 = 17'h00002;
    localparam logic [16:0] PCSRC2 = 17'h00004;
    localparam logic [16:0] B_DONE = 17'h00001;

    // Expected control word per state, written out from the behaviour table
    localparam logic [16:0] W_F1   = B_PCW | B_MRD | B_IRW | SRCB1;
    localparam logic [16:0] W_F0   = B_MRD | SRCB1;
    localparam logic [16:0] W_DEC  = SRCB3;
    localparam logic [16:0] W_MADR = B_SRCA | SRCB2;
    localparam logic [16:0] W_MRD  = B_MRD | B_IORD;
    localparam logic [16:0] W_MWB  = B_M2R | B_RWR | B_DONE;
    localparam logic [16:0] W_MWR0 = B_MWR | B_IORD;
    localparam logic [16:0] W_MWR1 = B_MWR | B_IORD | B_DONE;
    localparam logic [16:0] W_REXE = B_SRCA | ALUOP2;
    localparam logic [16:0] W_RWB  = B_RDST | B_RWR | B_DONE;
    localparam logic [16:0] W_BRN  = B_SRCA | ALUOP1 | B_PCWC | PCSRC1 | B_DONE;
    localparam logic [16:0] W_JMP  = B_PCW | PCSRC2 | B_DONE;
    localparam logic [16:0] W_AEXE = B_SRCA | SRCB2;
    localparam logic [16:0] W_AWB  = B_RWR | B_DONE;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] cw;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, RegDst, RegWrite, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, ALUOp, pc_source;
    logic [3:0] state;

    logic       d2_pc_write, d2_pc_write_cond, d2_i_or_d, d2_mem_read, d2_mem_write, d2_ir_write;
    logic       d2_mem_to_reg, d2_reg_dst, d2_reg_write, d2_alu_src_a, d2_illegal_op, d2_instr_done;
    logic [1:0] d2_alu_src_b, d2_alu_op, d2_pc_source;
    logic [3:0] d2_state;

    logic [16:0] cw_a;
    logic [5:0]  wen_a;

    int n_checks;
    int n_bad;
    vec_t vq[$];

    assign cw_a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, RegDst, RegWrite, alu_src_a, alu_src_b, ALUOp,
                   pc_source, instr_done};
    assign wen_a = {pc_write, pc_write_cond, mem_write, ir_write, RegWrite, mem_read};

    mips_mc_ctrl #(.EN_ADDI(1'b1), .EN_JUMP(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .RegDst(RegDst), .RegWrite(RegWrite),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
        .instr_done(instr_done)
    );

    mips_mc_ctrl #(.EN_ADDI(1'b0), .EN_JUMP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(d2_pc_write), .pc_write_cond(d2_pc_write_cond), .i_or_d(d2_i_or_d),
        .mem_read(d2_mem_read), .mem_write(d2_mem_write), .ir_write(d2_ir_write),
        .mem_to_reg(d2_mem_to_reg), .RegDst(d2_reg_dst), .RegWrite(d2_reg_write),
        .alu_src_a(d2_alu_src_a), .alu_src_b(d2_alu_src_b), .ALUOp(d2_alu_op),
        .pc_source(d2_pc_source), .state(d2_state), .illegal_op(d2_illegal_op),
        .instr_done(d2_instr_done)
    );

    // 10 time-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs (called right after a falling edge) and let them settle
    task automatic applyStimulus(input logic [5:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reset pulse ending on a falling edge, with the handshake idle
    task automatic doReset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'h00;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Step both instances from DECODE with the given opcode and check where
    // each one lands
    task automatic dispatchPair(input logic [5:0] op, input logic [3:0] exp1,
                                input logic [3:0] exp2, input logic exp2_ill);
        doReset();
        applyStimulus(op, 1'b1);
        @(negedge clk);
        #1;
        checkOutput($sformatf("d2_decode_st_%0h", op), 32'(d2_state), 32'd1);
        checkOutput($sformatf("d2_decode_ill_%0h", op), 32'(d2_illegal_op), 32'd0);
        @(negedge clk);
        #1;
        checkOutput($sformatf("d1_after_%0h", op), 32'(state), 32'(exp1));
        checkOutput($sformatf("d2_after_%0h", op), 32'(d2_state), 32'(exp2));
        checkOutput($sformatf("d2_ill_%0h", op), 32'(d2_illegal_op), 32'(exp2_ill));
        checkOutput($sformatf("d2_wen_%0h", op),
                    32'({d2_pc_write, d2_mem_write, d2_reg_write, d2_ir_write}), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        rst       = 1'b1;
        opcode    = 6'h00;
        mem_ready = 1'b0;

        // Per-cycle vectors: R-type, sw (with fetch stall), beq, j, addi,
        // lw with three wait cycles in MRD, then sw waiting one cycle in MWR.
        vq.push_back('{6'h00, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h00, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h00, 1'b1, 4'd6,  W_REXE});
        vq.push_back('{6'h00, 1'b1, 4'd7,  W_RWB});
        vq.push_back('{6'h2B, 1'b0, 4'd0,  W_F0});
        vq.push_back('{6'h2B, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h2B, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h2B, 1'b1, 4'd2,  W_MADR});
        vq.push_back('{6'h2B, 1'b1, 4'd5,  W_MWR1});
        vq.push_back('{6'h04, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h04, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h04, 1'b0, 4'd8,  W_BRN});
        vq.push_back('{6'h02, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h02, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h02, 1'b1, 4'd9,  W_JMP});
        vq.push_back('{6'h08, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h08, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h08, 1'b1, 4'd10, W_AEXE});
        vq.push_back('{6'h08, 1'b1, 4'd11, W_AWB});
        vq.push_back('{6'h23, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h23, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h23, 1'b0, 4'd2,  W_MADR});
        vq.push_back('{6'h23, 1'b0, 4'd3,  W_MRD});
        vq.push_back('{6'h23, 1'b0, 4'd3,  W_MRD});
        vq.push_back('{6'h23, 1'b0, 4'd3,  W_MRD});
        vq.push_back('{6'h23, 1'b1, 4'd3,  W_MRD});
        vq.push_back('{6'h23, 1'b0, 4'd4,  W_MWB});
        vq.push_back('{6'h2B, 1'b1, 4'd0,  W_F1});
        vq.push_back('{6'h2B, 1'b1, 4'd1,  W_DEC});
        vq.push_back('{6'h2B, 1'b1, 4'd2,  W_MADR});
        vq.push_back('{6'h2B, 1'b0, 4'd5,  W_MWR0});
        vq.push_back('{6'h2B, 1'b1, 4'd5,  W_MWR1});
        vq.push_back('{6'h00, 1'b1, 4'd0,  W_F1});

        // Asynchronous reset takes effect before any clock edge
        #1;
        checkOutput("reset_state_t0", 32'(state), 32'd0);
        checkOutput("reset_ill_t0", 32'(illegal_op), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_cw_notready", 32'(cw_a), 32'(W_F0));
        rst = 1'b0;

        foreach (vq[i]) begin
            applyStimulus(vq[i].op, vq[i].rdy);
            checkOutput($sformatf("vec%0d_state", i), 32'(state), 32'(vq[i].st));
            checkOutput($sformatf("vec%0d_ctrl", i), 32'(cw_a), 32'(vq[i].cw));
            checkOutput($sformatf("vec%0d_ill", i), 32'(illegal_op), 32'd0);
            @(negedge clk);
        end

        // Illegal opcode: enter TRAP, hold with no enables for 100 cycles
        doReset();
        applyStimulus(6'h3F, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("trap_decode_ill", 32'(illegal_op), 32'd0);
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            applyStimulus(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            checkOutput($sformatf("trap%0d", c), 32'({state, illegal_op, wen_a, instr_done}),
                        32'({4'd12, 1'b1, 6'd0, 1'b0}));
            @(negedge clk);
        end
        // Reset between edges clears the trap without waiting for a clock
        #2;
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        checkOutput("trap_rst_state", 32'(state), 32'd0);
        checkOutput("trap_rst_ill", 32'(illegal_op), 32'd0);
        checkOutput("trap_rst_cw", 32'(cw_a), 32'(W_F0));
        @(negedge clk);
        rst = 1'b0;

        // Disabled addi / j on the reduced instance trap; full instance runs
        dispatchPair(6'h08, 4'd10, 4'd12, 1'b1);
        dispatchPair(6'h02, 4'd9,  4'd12, 1'b1);
        dispatchPair(6'h00, 4'd6,  4'd6,  1'b0);

        // Reset arriving mid-MWR while memory is stalled
        doReset();
        applyStimulus(6'h2B, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        applyStimulus(6'h2B, 1'b0);
        checkOutput("mwr_state", 32'(state), 32'd5);
        checkOutput("mwr_wait_cw", 32'(cw_a), 32'(W_MWR0));
        #2;
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkOutput("mwr_rst_state", 32'(state), 32'd0);
        checkOutput("mwr_rst_cw", 32'(cw_a), 32'(W_F1));
        @(posedge clk);
        #1;
        checkOutput("mwr_rst_hold", 32'({state, mem_write, RegWrite, instr_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
